ones_comp_seq_div: RTL and testbench

//   Multi-cycle one's-complement divider: inverse of the ALU multiplier. Takes a

---
 rtl/agc_arith_pkg.sv | 36 +++
 rtl/restoring_div_step.sv | 27 ++
 rtl/ones_comp_seq_div.sv | 141 ++++++++++++++
 tb/tb_ones_comp_seq_div.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_arith_pkg.sv
// Shared one's-complement word types, divider FSM states and sign/magnitude helpers
// for the AGC-style ALU blocks.
package agc_arith_pkg;

  localparam int NUM_BIT = 15;

  typedef logic [NUM_BIT-1:0]   ones_word_t;
  typedef logic [2*NUM_BIT-1:0] ones_dword_t;
  typedef logic [NUM_BIT-2:0]   ones_mag_t;
  typedef logic [2*NUM_BIT-2:0] ones_dmag_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // A negative 1c value's magnitude is the bitwise inverse of its value bits.
  function automatic ones_mag_t ones_mag(input ones_word_t x);
    return x[NUM_BIT-1] ? ~x[NUM_BIT-2:0] : x[NUM_BIT-2:0];
  endfunction

  function automatic ones_dmag_t ones_dmag(input ones_dword_t x);
    return x[2*NUM_BIT-1] ? ~x[2*NUM_BIT-2:0] : x[2*NUM_BIT-2:0];
  endfunction

  // Sign is applied even to a zero magnitude, so a negative zero comes out as -0.
  function automatic ones_word_t ones_apply_sign(input logic s, input ones_mag_t m);
    ones_word_t w;
    w = {1'b0, m};
    return s ? ~w : w;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module restoring_div_step
  import agc_arith_pkg::*;
#(
  parameter int WIDTH = NUM_BIT
) (
  input  logic [WIDTH-2:0] rem_in,
  input  logic [WIDTH-2:0] dmag,
  input  logic             next_bit,
  output logic [WIDTH-2:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;

  // rem_in < dmag always holds, so shifted never exceeds 2*dmag and the
  // restored/subtracted result fits back into WIDTH-1 bits.
  always_comb begin
    shifted = {rem_in, next_bit};
    diff    = shifted - {1'b0, dmag};
    q_bit   = (shifted >= {1'b0, dmag});
    rem_out = q_bit ? diff[WIDTH-2:0] : shifted[WIDTH-2:0];
  end

endmodule

// File: rtl/ones_comp_seq_div.sv
// Multi-cycle one's-complement divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// sign-magnitude restoring division producing one quotient bit per clock.
module ones_comp_seq_div
  import agc_arith_pkg::*;
#(
  parameter int WIDTH = NUM_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] numer,
  input  logic [WIDTH-1:0]   denom,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   remain,
  output logic               overflow,
  output logic               div_by_zero,
  output div_state_t         fsm_state
);

  // Handshake: a transfer happens on a clock edge where valid & ready are both
  // high. in_ready is high only in IDLE; out_valid is high only in DONE and stays
  // high with stable outputs until out_ready is seen.

  localparam int ITER_N = WIDTH - 1;
  localparam int CW     = $clog2(ITER_N);

  div_state_t state, next_state;

  logic [2*WIDTH-1:0] numer_q;
  logic [WIDTH-1:0]   denom_q;
  logic [WIDTH-2:0]   nlow;
  logic [WIDTH-2:0]   prem;
  logic [WIDTH-2:0]   dmag;
  logic [WIDTH-2:0]   qmag;
  logic               q_sign;
  logic               r_sign;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-2:0] nmag_c;
  logic [WIDTH-2:0]   dmag_c;
  logic               ovf_c;
  logic [WIDTH-2:0]   step_rem;
  logic               step_q;

  assign fsm_state = state;

  // Overflow when the quotient would need more than ITER_N bits; with a zero
  // divisor the compare is always true, which also covers divide by zero.
  always_comb begin
    nmag_c = ones_dmag(numer_q);
    dmag_c = ones_mag(denom_q);
    ovf_c  = (nmag_c[2*WIDTH-2:WIDTH-1] >= {1'b0, dmag_c});
  end

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (prem),
    .dmag     (dmag),
    .next_bit (nlow[cnt]),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = LOAD;
      end
      LOAD: next_state = ovf_c ? SIGN : ITER;
      ITER: if (cnt == '0) next_state = SIGN;
      SIGN: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      numer_q     <= '0;
      denom_q     <= '0;
      nlow        <= '0;
      prem        <= '0;
      dmag        <= '0;
      qmag        <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      cnt         <= '0;
      quot        <= '0;
      remain      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            numer_q     <= numer;
            denom_q     <= denom;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        LOAD: begin
          dmag        <= dmag_c;
          prem        <= nmag_c[2*WIDTH-3:WIDTH-1];
          nlow        <= nmag_c[WIDTH-2:0];
          q_sign      <= numer_q[2*WIDTH-1] ^ denom_q[WIDTH-1];
          r_sign      <= numer_q[2*WIDTH-1];
          div_by_zero <= (dmag_c == '0);
          overflow    <= ovf_c;
          cnt         <= CW'(ITER_N - 1);
          qmag        <= '0;
        end
        ITER: begin
          prem <= step_rem;
          qmag <= {qmag[WIDTH-3:0], step_q};
          cnt  <= cnt - 1'b1;
        end
        SIGN: begin
          quot   <= ones_apply_sign(q_sign, overflow ? '1 : qmag);
          remain <= ones_apply_sign(r_sign, overflow ? '0 : prem);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_comp_seq_div.sv
// Self-checking bench for ones_comp_seq_div: directed table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_ones_comp_seq_div;
  import agc_arith_pkg::*;

  localparam int W = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  numer;
  logic [W-1:0]    denom;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    quot;
  logic [W-1:0]    remain;
  logic            overflow;
  logic            div_by_zero;
  div_state_t      fsm_state;

  int checks = 0;
  int errors = 0;

  ones_comp_seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .numer       (numer),
    .denom       (denom),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .remain      (remain),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dbz;
    int             lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed magnitudes divided with plain integer arithmetic.
  task automatic ref_div(input logic [2*W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic ovf, output logic dbz);
    logic [2*W-2:0] nm;
    logic [W-2:0]   dm;
    longint         nv, dv, qv, rv;
    logic [W-1:0]   qw, rw;
    nm  = n[2*W-1] ? ~n[2*W-2:0] : n[2*W-2:0];
    dm  = d[W-1] ? ~d[W-2:0] : d[W-2:0];
    nv  = longint'(nm);
    dv  = longint'(dm);
    dbz = (dv == 0);
    ovf = dbz || ((nv / dv) >= (64'sd1 << (W - 1)));
    qv  = ovf ? ((64'sd1 << (W - 1)) - 1) : nv / dv;
    rv  = ovf ? 0 : nv % dv;
    qw  = W'(qv);
    rw  = W'(rv);
    q   = (n[2*W-1] ^ d[W-1]) ? ~qw : qw;
    r   = n[2*W-1] ? ~rw : rw;
  endtask

  task automatic start_op(input logic [2*W-1:0] n, input logic [W-1:0] d);
    int waited;
    waited = 0;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    numer    = n;
    denom    = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic [2*W-1:0] n, input logic [W-1:0] d,
                             input logic early_ready);
    logic [W-1:0] eq, er;
    logic         eo, ez;
    int           lat;
    ref_div(n, d, eq, er, eo, ez);
    out_ready = early_ready;
    start_op(n, d);
    wait_result(lat);
    check({name, "_quot"}, 32'(quot), 32'(eq));
    check({name, "_remain"}, 32'(remain), 32'(er));
    check({name, "_overflow"}, 32'(overflow), 32'(eo));
    check({name, "_div_by_zero"}, 32'(div_by_zero), 32'(ez));
    check({name, "_latency"}, 32'(lat), eo ? 32'd2 : 32'd16);
    handshake();
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0]   rq, rr;
    logic           ro, rz;
    logic [W-1:0]   d;
    logic [W-2:0]   dm;
    logic [2*W-2:0] nm;
    int             lat;

    vecs[0] = '{"pos_100_7",    30'd100,    15'd7,      15'd14,     15'd2,      1'b0, 1'b0, 16};
    vecs[1] = '{"neg_numer",    ~30'd100,   15'd7,      15'h7FF1,   15'h7FFD,   1'b0, 1'b0, 16};
    vecs[2] = '{"neg_denom",    30'd100,    15'h7FF8,   15'h7FF1,   15'd2,      1'b0, 1'b0, 16};
    vecs[3] = '{"max_quot",     30'd114687, 15'd7,      15'h3FFF,   15'd6,      1'b0, 1'b0, 16};
    vecs[4] = '{"ovf_edge",     30'd114688, 15'd7,      15'h3FFF,   15'd0,      1'b1, 1'b0, 2};
    vecs[5] = '{"div_neg_zero", 30'd100,    15'h7FFF,   15'h4000,   15'd0,      1'b1, 1'b1, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; numer = '0; denom = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quot", 32'(quot), 32'd0);
    check("reset_remain", 32'(remain), 32'd0);
    check("reset_flags", {30'd0, overflow, div_by_zero}, 32'd0);
    check("reset_state", 32'(fsm_state), 32'(IDLE));

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].n, vecs[i].d);
      wait_result(lat);
      check({vecs[i].name, "_quot"}, 32'(quot), 32'(vecs[i].q));
      check({vecs[i].name, "_remain"}, 32'(remain), 32'(vecs[i].r));
      check({vecs[i].name, "_overflow"}, 32'(overflow), 32'(vecs[i].ovf));
      check({vecs[i].name, "_div_by_zero"}, 32'(div_by_zero), 32'(vecs[i].dbz));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      handshake();
      check({vecs[i].name, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({vecs[i].name, "_ready_back"}, 32'(in_ready), 32'd1);
    end

    // Input offered while busy must be ignored; result held while out_ready low.
    start_op(30'd100, 15'd7);
    repeat (3) tick();
    in_valid = 1'b1; numer = 30'd200; denom = 15'd3;
    for (int i = 0; i < 4; i++) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quot", 32'(quot), 32'd14);
      check("hold_remain", 32'(remain), 32'd2);
      tick();
    end
    handshake();
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    check("no_phantom_op", 32'(in_ready), 32'd1);

    // Reset during iteration step 7 discards the operation.
    start_op(30'd1000, 15'd9);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quot", 32'(quot), 32'd0);
    check("midrst_remain", 32'(remain), 32'd0);
    check("midrst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
    run_checked("after_rst", 30'd1000, 15'd9, 1'b0);

    // out_ready held high from the start gives a one-cycle out_valid pulse.
    run_checked("early_ready", 30'd12345, 15'd77, 1'b1);

    for (int i = 0; i < 40; i++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 3) == 0) begin
        run_checked("rand_any", {$urandom(), $urandom()} >> 34, d, 1'($urandom_range(0, 1)));
      end else begin
        dm = d[W-1] ? ~d[W-2:0] : d[W-2:0];
        if (dm == '0) begin
          d  = 15'd5;
          dm = 14'd5;
        end
        nm = (2*W-1)'($urandom() % (32'(dm) << (W - 1)));
        run_checked("rand_inrange", $urandom_range(0, 1) ? ~{1'b0, nm} : {1'b0, nm}, d,
                    1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    ref_div(30'd7, 15'd0, rq, rr, ro, rz);
    run_checked("pos_zero_div", 30'd7, 15'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
